mdu_unit: RTL and testbench
===========================

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL declare parameters: MULT_LAT, default 5, multiply busy cycles; DIV_LAT, default 10, divide busy cycles.
REQ-002 SHALL declare clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL declare reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL declare start  input  1  one-cycle request, qualified by op.
REQ-005 SHALL declare op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-006 SHALL declare rs_val  input  32  operand A / move source.
REQ-007 SHALL declare rt_val  input  32  operand B.
REQ-008 SHALL declare rd_hi  input  1  read select: 1 HI, 0 LO.
REQ-009 SHALL declare busy  output  1  operation in flight; consumed by the stall controller to drop pipeline-register enable.
REQ-010 SHALL declare mdu_out  output  32  combinational HI or LO per rd_hi; this is the M-stage mduans value.
REQ-011 SHALL declare hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-012 SHALL sample start/op/rs_val/rt_val at a rising edge T only when busy=0; a start with busy=1 is ignored entirely.
REQ-013 For ops 1-4 accepted at T, busy SHALL be 1 after edges T..T+N-1 and 0 after edge T+N (N=MULT_LAT for 1-2, DIV_LAT for 3-4).
REQ-014 HI/LO SHALL update at edge T+N, the same edge busy falls; HI/LO SHALL hold their old values while busy=1.
REQ-015 Operands SHALL be latched at T; later changes on rs_val/rt_val SHALL not affect the result.
REQ-016 mult: {HI,LO} = signed 64-bit rs*rt; multu: unsigned 64-bit product.
REQ-017 div: LO = quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-018 div with 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-019 Divide by zero (div or divu) SHALL still hold busy for DIV_LAT cycles, then leave HI/LO unchanged.
REQ-020 mthi/mtlo accepted at T SHALL write rs_val into HI/LO at edge T, busy remains 0.
REQ-021 mthi/mtlo presented while busy=1 SHALL be ignored.
REQ-022 A down-counter (width >= clog2(DIV_LAT+1)) SHALL time operations; busy = (counter != 0).
REQ-023 Back-to-back start SHALL be accepted on the edge where busy falls only if busy=0 when sampled, i.e. the cycle after the result lands.
REQ-024 mdu_out SHALL reflect HI/LO as currently registered, with no forwarding of a pending result.

Reset
REQ-025 On reset=1 at an edge: HI=0, LO=0, counter=0, busy=0, pending result discarded.
REQ-026 Reset SHALL override a simultaneous start; a reset mid-operation SHALL produce no later HI/LO update.

Structure
REQ-027 Package mdu_pkg SHALL hold the op encodings (MDU_NONE..MDU_MTLO) and the default latency constants.
REQ-028 The 64-bit result SHALL be computed once at acceptance and held in a pending register until commit; no sub-module required.

Verification
REQ-029 multu rs=0xFFFFFFFF rt=2 -> busy high exactly 5 cycles, then HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 mult rs=0xFFFFFFFD(-3) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; div rs=-7 rt=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-031 mthi 0x1234, mtlo 0x5678, then divu rt=0 -> busy 10 cycles, HI=0x1234, LO=0x5678 unchanged.
REQ-032 mult accepted, reset asserted in the 3rd busy cycle -> next edge busy=0, HI=LO=0, no update at original commit edge.
REQ-033 mult accepted, then start mtlo 0xAAAA and start div while busy -> both ignored; only mult result lands; rd_hi toggles mdu_out between HI/LO.
REQ-034 div 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared definitions for the multiply/divide unit: op encodings,
//            default busy latencies and the 64-bit result helper.
// Contents : mdu_op_e          - op field encoding (7 is reserved, acts as none)
//            MULT_LAT_DEFAULT  - default multiply busy cycles
//            DIV_LAT_DEFAULT   - default divide busy cycles
//            mdu_result()      - {HI,LO} for mult/multu/div/divu
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  localparam int MULT_LAT_DEFAULT = 5;
  localparam int DIV_LAT_DEFAULT  = 10;

  // Returns {HI,LO}. Divide-by-zero yields a don't-care value; the caller
  // suppresses the commit in that case.
  function automatic logic [63:0] mdu_result(input logic [2:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] b_safe;
    logic        [63:0] res;

    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    // Keep the dividers well defined when the divisor is zero.
    b_safe = (b == 32'd0) ? 32'd1 : b;
    quot_s = $signed(a) / $signed(b_safe);
    rem_s  = $signed(a) % $signed(b_safe);
    res    = 64'd0;

    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV: begin
        // Most-negative / -1 overflows 32 bits; the wrapped quotient is the
        // dividend itself with a zero remainder.
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          res = {32'h0000_0000, 32'h8000_0000};
        else
          res = {rem_s, quot_s};
      end
      MDU_DIVU:  res = {a % b_safe, a / b_safe};
      default:   res = 64'd0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO.
//            The result is computed when an op is accepted, parked in a
//            pending register and committed when the busy counter expires.
// Ports    : clk     - clock, rising edge
//            reset   - synchronous active-high reset
//            start   - one-cycle request qualified by op
//            op      - mdu_op_e encoding
//            rs_val  - operand A / move source
//            rt_val  - operand B
//            rd_hi   - read select for mdu_out (1 HI, 0 LO)
//            busy    - operation in flight
//            mdu_out - HI or LO as currently registered
//            hi, lo  - architectural HI/LO
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] mdu_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [63:0]      pend;
  logic             pend_wr;   // cleared for divide-by-zero: HI/LO untouched

  assign busy    = (cnt != '0);
  assign mdu_out = rd_hi ? hi : lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      cnt     <= '0;
      pend    <= 64'd0;
      pend_wr <= 1'b0;
    end else if (busy) begin
      // Requests arriving while busy are dropped; the commit lands on the
      // same edge the counter reaches zero.
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE && pend_wr) begin
        hi <= pend[63:32];
        lo <= pend[31:0];
      end
    end else if (start) begin
      pend <= mdu_result(op, rs_val, rt_val);
      case (op)
        MDU_MULT, MDU_MULTU: begin
          cnt     <= MULT_CNT;
          pend_wr <= 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          cnt     <= DIV_CNT;
          pend_wr <= (rt_val != 32'd0);
        end
        MDU_MTHI: hi <= rs_val;
        MDU_MTLO: lo <= rs_val;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_unit
// Purpose  : Self-checking bench for mdu_unit. A cycle-numbered reference
//            model (longint arithmetic, commit-cycle bookkeeping) is checked
//            against the DUT after every rising edge; directed sequences pin
//            the model with hand-computed literals, then random traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_hi;
  logic        busy;
  logic [31:0] mdu_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int errors  = 0;

  mdu_unit #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .rd_hi   (rd_hi),
    .busy    (busy),
    .mdu_out (mdu_out),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Edge numbers count rising edges. An op accepted at edge T commits at
  // edge done = T + latency; busy is visible after edges T .. done-1.
  int          edge_no  = 0;
  int          done     = 0;
  bit          pend_ok  = 0;
  logic [63:0] pend_val = 64'd0;
  logic [31:0] m_hi     = 32'd0;
  logic [31:0] m_lo     = 32'd0;

  always @(posedge clk) begin : model_and_compare
    longint sa, sb, q, r;
    edge_no++;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; done = 0; pend_ok = 0;
    end else begin
      if (edge_no == done && pend_ok) begin
        m_hi = pend_val[63:32];
        m_lo = pend_val[31:0];
      end
      if (edge_no > done && start) begin
        case (op)
          3'd1: begin
            sa = longint'($signed(rs_val)); sb = longint'($signed(rt_val));
            pend_val = sa * sb; pend_ok = 1; done = edge_no + MLAT;
          end
          3'd2: begin
            sa = longint'({32'd0, rs_val}); sb = longint'({32'd0, rt_val});
            pend_val = sa * sb; pend_ok = 1; done = edge_no + MLAT;
          end
          3'd3, 3'd4: begin
            if (op == 3'd3) begin
              sa = longint'($signed(rs_val)); sb = longint'($signed(rt_val));
            end else begin
              sa = longint'({32'd0, rs_val}); sb = longint'({32'd0, rt_val});
            end
            pend_ok = (sb != 0);
            if (sb != 0) begin
              q = sa / sb; r = sa % sb;
              pend_val = {r[31:0], q[31:0]};
            end
            done = edge_no + DLAT;
          end
          3'd5: m_hi = rs_val;
          3'd6: m_lo = rs_val;
          default: ;
        endcase
      end
    end
    #1;
    check32("busy", {31'd0, busy}, {31'd0, (edge_no < done)});
    check32("hi", hi, m_hi);
    check32("lo", lo, m_lo);
    check32("mdu_out", mdu_out, rd_hi ? m_hi : m_lo);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic st, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic rd, input logic rst);
    @(negedge clk);
    start = st; op = o; rs_val = a; rt_val = b; rd_hi = rd; reset = rst;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; rd_hi = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    check32("reset_busy", {31'd0, busy}, 32'd0);

    // multu 0xFFFFFFFF * 2: busy exactly 5 cycles, operands changed afterwards
    drive(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    check32("multu_busy0", {31'd0, busy}, 32'd1);
    for (int i = 1; i < MLAT; i++) begin
      drive(1'b0, 3'd0, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
      check32("multu_busy", {31'd0, busy}, 32'd1);
      check32("multu_hold_lo", lo, 32'd0);
    end
    idle(1);
    check32("multu_done_busy", {31'd0, busy}, 32'd0);
    check32("multu_hi", hi, 32'h0000_0001);
    check32("multu_lo", lo, 32'hFFFF_FFFE);

    // mult -3 * 7
    drive(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    idle(MLAT);
    check32("mult_hi", hi, 32'hFFFF_FFFF);
    check32("mult_lo", lo, 32'hFFFF_FFEB);

    // div -7 / 2
    drive(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(DLAT - 1);
    check32("div_busy_last", {31'd0, busy}, 32'd1);
    idle(1);
    check32("div_lo", lo, 32'hFFFF_FFFD);
    check32("div_hi", hi, 32'hFFFF_FFFF);

    // mthi / mtlo then divu by zero leaves them intact
    drive(1'b1, 3'd5, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    check32("mthi_nobusy", {31'd0, busy}, 32'd0);
    drive(1'b1, 3'd6, 32'h0000_5678, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 3'd4, 32'h0000_0099, 32'd0, 1'b0, 1'b0);
    idle(DLAT - 1);
    check32("divz_busy", {31'd0, busy}, 32'd1);
    idle(1);
    check32("divz_busy_end", {31'd0, busy}, 32'd0);
    check32("divz_hi", hi, 32'h0000_1234);
    check32("divz_lo", lo, 32'h0000_5678);

    // div overflow case
    drive(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(DLAT);
    check32("divovf_lo", lo, 32'h8000_0000);
    check32("divovf_hi", hi, 32'h0000_0000);

    // reset during the third busy cycle of a mult
    drive(1'b1, 3'd1, 32'd100, 32'd200, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check32("rstmid_busy", {31'd0, busy}, 32'd0);
    check32("rstmid_hi", hi, 32'd0);
    idle(4);
    check32("rstmid_lo_late", lo, 32'd0);

    // requests while busy are dropped; rd_hi selects the output
    drive(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    drive(1'b1, 3'd6, 32'h0000_AAAA, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 3'd3, 32'd50, 32'd3, 1'b0, 1'b0);
    idle(MLAT - 2);
    check32("ign_busy_end", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rd_hi = 1'b1; #1;
    check32("ign_out_hi", mdu_out, 32'hFFFF_FFFF);
    rd_hi = 1'b0; #1;
    check32("ign_out_lo", mdu_out, 32'hFFFF_FFEB);
    idle(DLAT + 2);
    check32("ign_lo_final", lo, 32'hFFFF_FFEB);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
            1'($urandom_range(0, 1)), ($urandom_range(0, 79) == 0));
    end
    idle(DLAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
